// File: rtl/dram_arbiter.sv
// DRAM slot arbiter: shares one 16-bit DRAM port between video, DMA and CPU.
// A slot spans one c0..c3 phase rotation. The next owner is picked during c3.
// Continuous CPU traffic cannot starve a pending DMA request.
module dram_arbiter #(
   parameter int unsigned DMA_STARVE = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c0,
   input  logic        c1,
   input  logic        c2,
   input  logic        c3,
   input  logic        video_req,
   input  logic [20:0] video_addr,
   output logic        video_next,
   output logic        video_strobe,
   input  logic        dma_req,
   input  logic        dma_rnw,
   input  logic [20:0] dma_addr,
   input  logic [15:0] dma_wrdata,
   input  logic [1:0]  dma_bsel,
   output logic        dma_next,
   output logic        dma_strobe,
   input  logic        cpu_req,
   input  logic        cpu_rnw,
   input  logic [20:0] cpu_addr,
   input  logic [7:0]  cpu_wrdata,
   input  logic        cpu_wrbsel,
   output logic        cpu_next,
   output logic        cpu_strobe,
   output logic        cpu_latch,
   output logic [15:0] cpu_rddata,
   output logic        dram_req,
   output logic        dram_rnw,
   output logic [20:0] dram_addr,
   output logic [15:0] dram_wrdata,
   output logic [1:0]  dram_bsel,
   input  logic [15:0] dram_rddata
);

   localparam int unsigned AW = 21;
   localparam int unsigned DW = 16;
   localparam int unsigned BW = 2;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_VIDEO = 2'd1,
      OWN_DMA   = 2'd2,
      OWN_CPU   = 2'd3
   } owner_t;

   owner_t           r_owner;
   owner_t           w_owner_nxt;
   owner_t           w_grant;
   logic [CNT_W-1:0] r_cnt;
   logic             w_starved;

   logic             r_dram_req;
   logic             r_dram_rnw;
   logic [AW-1:0]    r_dram_addr;
   logic [DW-1:0]    r_dram_wrdata;
   logic [BW-1:0]    r_dram_bsel;
   logic             w_slot_rnw;
   logic [AW-1:0]    w_slot_addr;
   logic [DW-1:0]    w_slot_wrdata;
   logic [BW-1:0]    w_slot_bsel;

   logic [DW-1:0]    r_cpu_rddata;
   logic             r_cpu_latch;

   // c0/c1 are part of the phase contract but carry no decision of their own
   logic             w_unused_phase;
   assign w_unused_phase = c0 ^ c1;

   assign w_starved = (r_cnt == CNT_W'(DMA_STARVE));

   // Next-state: fixed-priority grant, applied only on the c3 clock
   always_comb begin
      w_grant = OWN_NONE;
      if (video_req) begin
         w_grant = OWN_VIDEO;
      end else if (dma_req && w_starved) begin
         w_grant = OWN_DMA;
      end else if (cpu_req) begin
         w_grant = OWN_CPU;
      end else if (dma_req) begin
         w_grant = OWN_DMA;
      end
      w_owner_nxt = c3 ? w_grant : r_owner;
   end

   // State register: current slot owner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner <= OWN_NONE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   // Outputs: grant notifications during c3, read strobes during c2
   always_comb begin
      video_next   = 1'b0;
      dma_next     = 1'b0;
      cpu_next     = 1'b0;
      video_strobe = 1'b0;
      dma_strobe   = 1'b0;
      cpu_strobe   = 1'b0;
      if (c3 && !rst) begin
         video_next = (w_grant == OWN_VIDEO);
         dma_next   = (w_grant == OWN_DMA);
         cpu_next   = (w_grant == OWN_CPU);
      end
      if (c2 && r_dram_rnw) begin
         video_strobe = (r_owner == OWN_VIDEO);
         dma_strobe   = (r_owner == OWN_DMA);
         cpu_strobe   = (r_owner == OWN_CPU);
      end
   end

   // DRAM command for the winner; CPU byte writes are replicated on both lanes
   always_comb begin
      w_slot_rnw    = 1'b0;
      w_slot_addr   = '0;
      w_slot_wrdata = '0;
      w_slot_bsel   = '0;
      case (w_grant)
         OWN_VIDEO: begin
            w_slot_rnw  = 1'b1;
            w_slot_addr = video_addr;
            w_slot_bsel = 2'b11;
         end
         OWN_DMA: begin
            w_slot_rnw    = dma_rnw;
            w_slot_addr   = dma_addr;
            w_slot_wrdata = dma_wrdata;
            w_slot_bsel   = dma_bsel;
         end
         OWN_CPU: begin
            w_slot_rnw    = cpu_rnw;
            w_slot_addr   = cpu_addr;
            w_slot_wrdata = {cpu_wrdata, cpu_wrdata};
            if (cpu_rnw) begin
               w_slot_bsel = 2'b11;
            end else begin
               w_slot_bsel = cpu_wrbsel ? 2'b10 : 2'b01;
            end
         end
         default: begin
         end
      endcase
   end

   // Slot command registers, loaded once per slot on c3
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dram_req    <= 1'b0;
         r_dram_rnw    <= 1'b0;
         r_dram_addr   <= '0;
         r_dram_wrdata <= '0;
         r_dram_bsel   <= '0;
      end else if (c3) begin
         r_dram_req    <= (w_grant != OWN_NONE);
         r_dram_rnw    <= w_slot_rnw;
         r_dram_addr   <= w_slot_addr;
         r_dram_wrdata <= w_slot_wrdata;
         r_dram_bsel   <= w_slot_bsel;
      end
   end

   // Starvation counter: counts CPU wins over a waiting DMA, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (c3) begin
         if (!dma_req || (w_grant == OWN_DMA)) begin
            r_cnt <= '0;
         end else if ((w_grant == OWN_CPU) && !w_starved) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // CPU read capture; latch stays up across back-to-back CPU reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpu_rddata <= '0;
         r_cpu_latch  <= 1'b0;
      end else if (cpu_strobe) begin
         r_cpu_rddata <= dram_rddata;
         r_cpu_latch  <= 1'b1;
      end else if (c2) begin
         r_cpu_latch  <= 1'b0;
      end
   end

   assign dram_req    = r_dram_req;
   assign dram_rnw    = r_dram_rnw;
   assign dram_addr   = r_dram_addr;
   assign dram_wrdata = r_dram_wrdata;
   assign dram_bsel   = r_dram_bsel;
   assign cpu_rddata  = r_cpu_rddata;
   assign cpu_latch   = r_cpu_latch;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios followed by random
// traffic, all checked against a slot-level reference model.
module tb_dram_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0, c1, c2, c3;
   logic        video_req;
   logic [20:0] video_addr;
   logic        video_next, video_strobe;
   logic        dma_req, dma_rnw;
   logic [20:0] dma_addr;
   logic [15:0] dma_wrdata;
   logic [1:0]  dma_bsel;
   logic        dma_next, dma_strobe;
   logic        cpu_req, cpu_rnw;
   logic [20:0] cpu_addr;
   logic [7:0]  cpu_wrdata;
   logic        cpu_wrbsel;
   logic        cpu_next, cpu_strobe, cpu_latch;
   logic [15:0] cpu_rddata;
   logic        dram_req, dram_rnw;
   logic [20:0] dram_addr;
   logic [15:0] dram_wrdata;
   logic [1:0]  dram_bsel;
   logic [15:0] dram_rddata;

   always #5 clk = ~clk;

   dram_arbiter #(.DMA_STARVE(STARVE), .CNT_W(3)) u_dut (
      .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
      .video_req(video_req), .video_addr(video_addr),
      .video_next(video_next), .video_strobe(video_strobe),
      .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
      .dma_wrdata(dma_wrdata), .dma_bsel(dma_bsel),
      .dma_next(dma_next), .dma_strobe(dma_strobe),
      .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
      .cpu_wrdata(cpu_wrdata), .cpu_wrbsel(cpu_wrbsel),
      .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
      .cpu_rddata(cpu_rddata),
      .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
      .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel),
      .dram_rddata(dram_rddata)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model (owner: 0 none, 1 video, 2 dma, 3 cpu)
   int          ph;
   int          last_g;
   int          m_owner, m_cnt;
   bit          m_req, m_rnw;
   logic [20:0] m_addr;
   logic [15:0] m_wd;
   logic [1:0]  m_bsel;
   logic [15:0] m_rd;
   bit          m_latch;
   int          grant_log[$];
   bit          rnd_data;

   function automatic int winner();
      if (video_req) return 1;
      if (dma_req && m_cnt == STARVE) return 2;
      if (cpu_req) return 3;
      if (dma_req) return 2;
      return 0;
   endfunction

   task automatic m_reset();
      m_owner = 0; m_cnt = 0; m_req = 0; m_rnw = 0;
      m_addr = '0; m_wd = '0; m_bsel = '0; m_rd = '0; m_latch = 0;
   endtask

   task automatic set_ph(input int p);
      ph = p;
      c0 = (p == 0); c1 = (p == 1); c2 = (p == 2); c3 = (p == 3);
   endtask

   // Model the effect of one clock edge
   task automatic m_edge(input int g);
      if (rst) begin
         m_reset();
         return;
      end
      if (ph == 2) begin
         if (m_owner == 3 && m_rnw) begin
            m_rd    = dram_rddata;
            m_latch = 1;
         end else begin
            m_latch = 0;
         end
      end
      if (ph == 3) begin
         if (g == 3 && dma_req) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
         else if (g == 2 || !dma_req) m_cnt = 0;
         m_owner = g;
         m_req   = (g != 0);
         case (g)
            1: begin m_rnw = 1; m_addr = video_addr; m_bsel = 2'b11; end
            2: begin m_rnw = dma_rnw; m_addr = dma_addr; m_wd = dma_wrdata; m_bsel = dma_bsel; end
            3: begin
               m_rnw  = cpu_rnw; m_addr = cpu_addr; m_wd = {cpu_wrdata, cpu_wrdata};
               m_bsel = cpu_rnw ? 2'b11 : (cpu_wrbsel ? 2'b10 : 2'b01);
            end
            default: m_rnw = 0;
         endcase
      end
   endtask

   task automatic chk_regs();
      chk("dram_req", 32'(dram_req), 32'(m_req));
      chk("cpu_latch", 32'(cpu_latch), 32'(m_latch));
      chk("cpu_rddata", 32'(cpu_rddata), 32'(m_rd));
      if (m_req) begin
         chk("dram_rnw", 32'(dram_rnw), 32'(m_rnw));
         chk("dram_addr", 32'(dram_addr), 32'(m_addr));
         chk("dram_bsel", 32'(dram_bsel), 32'(m_bsel));
         if (!m_rnw) chk("dram_wrdata", 32'(dram_wrdata), 32'(m_wd));
      end
   endtask

   // One clock: check combinational outputs, clock edge, check registers
   task automatic step();
      int g;
      logic [2:0] exp_next, exp_stb;
      g = (ph == 3) ? winner() : -1;
      exp_next = 3'b000;
      if (ph == 3 && !rst) exp_next = {g == 1, g == 2, g == 3};
      exp_stb = 3'b000;
      if (ph == 2 && m_rnw) exp_stb = {m_owner == 1, m_owner == 2, m_owner == 3};
      #1;
      chk("next", 32'({video_next, dma_next, cpu_next}), 32'(exp_next));
      chk("strobe", 32'({video_strobe, dma_strobe, cpu_strobe}), 32'(exp_stb));
      @(posedge clk);
      m_edge(g);
      last_g = -1;
      if (ph == 3 && !rst) begin
         last_g = g;
         if (g != 0) grant_log.push_back(g);
      end
      @(negedge clk);
      chk_regs();
      set_ph((ph + 1) % 4);
      if (rnd_data) dram_rddata = 16'($urandom);
   endtask

   // Run until just after the next c3 edge
   task automatic to_slot();
      do step(); while (last_g < 0 || rst);
   endtask

   // Requesters may change only when idle or just granted
   task automatic rand_reqs();
      if (!video_req || last_g == 1) begin
         video_req  = ($urandom_range(0, 3) == 0);
         video_addr = 21'($urandom);
      end
      if (!dma_req || last_g == 2) begin
         dma_req    = ($urandom_range(0, 2) == 0);
         dma_rnw    = 1'($urandom);
         dma_addr   = 21'($urandom);
         dma_wrdata = 16'($urandom);
         dma_bsel   = 2'($urandom);
      end
      if (!cpu_req || last_g == 3) begin
         cpu_req    = ($urandom_range(0, 1) == 0);
         cpu_rnw    = 1'($urandom);
         cpu_addr   = 21'($urandom);
         cpu_wrdata = 8'($urandom);
         cpu_wrbsel = 1'($urandom);
      end
   endtask

   initial begin
      int exp_order[13];
      exp_order = '{3, 3, 1, 1, 1, 3, 3, 2, 3, 3, 3, 3, 2};
      rnd_data = 0; last_g = -1;
      rst = 1'b1;
      video_req = 0; video_addr = '0;
      dma_req = 0; dma_rnw = 0; dma_addr = '0; dma_wrdata = '0; dma_bsel = '0;
      cpu_req = 0; cpu_rnw = 0; cpu_addr = '0; cpu_wrdata = '0; cpu_wrbsel = 0;
      dram_rddata = 16'hBEEF;
      set_ph(0);
      m_reset();
      #2;
      chk("rst_dram_req", 32'(dram_req), 32'd0);
      chk("rst_bsel", 32'(dram_bsel), 32'd0);
      chk("rst_rddata", 32'(cpu_rddata), 32'd0);
      chk("rst_latch", 32'(cpu_latch), 32'd0);

      // Reset released during c1 with a CPU read pending
      cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h01234;
      repeat (5) step();
      rst = 1'b0;
      to_slot();
      chk("t1_grant", 32'(last_g), 32'd3);
      chk("t1_req", 32'(dram_req), 32'd1);
      chk("t1_addr", 32'(dram_addr), 32'h01234);
      chk("t1_bsel", 32'(dram_bsel), 32'h3);
      cpu_req = 0;
      repeat (3) step();
      chk("t1_rddata", 32'(cpu_rddata), 32'hBEEF);
      chk("t1_latch", 32'(cpu_latch), 32'd1);

      // CPU write, upper byte lane
      cpu_req = 1; cpu_rnw = 0; cpu_wrdata = 8'h5A; cpu_wrbsel = 1; cpu_addr = 21'h1F00F;
      to_slot();
      chk("wr_wrdata", 32'(dram_wrdata), 32'h5A5A);
      chk("wr_bsel", 32'(dram_bsel), 32'h2);
      chk("wr_rnw", 32'(dram_rnw), 32'd0);
      cpu_req = 0;
      repeat (3) step();
      chk("wr_latch", 32'(cpu_latch), 32'd0);

      // Counter: two CPU wins, video blocks three slots, then starvation rotation
      grant_log.delete();
      cpu_req = 1; cpu_rnw = 1; dma_req = 1; dma_rnw = 1; dma_bsel = 2'b11;
      repeat (2) to_slot();
      video_req = 1; video_addr = 21'h0ABCD;
      repeat (3) to_slot();
      video_req = 0;
      repeat (8) to_slot();
      chk("order_len", 32'(grant_log.size()), 32'd13);
      for (int i = 0; i < 13 && i < grant_log.size(); i++)
         chk($sformatf("order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));

      // Idle: no requests
      cpu_req = 0; dma_req = 0;
      repeat (3) begin
         to_slot();
         chk("idle_req", 32'(dram_req), 32'd0);
      end

      // Reset pulse during c1 of a CPU read slot
      cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h00777; dram_rddata = 16'h1357;
      to_slot();
      cpu_req = 0;
      step();
      rst = 1'b1;
      #1;
      chk("rstm_req", 32'(dram_req), 32'd0);
      chk("rstm_rddata", 32'(cpu_rddata), 32'd0);
      m_reset();
      step();
      rst = 1'b0;
      step();
      chk("rstm_post_rddata", 32'(cpu_rddata), 32'd0);
      chk("rstm_post_latch", 32'(cpu_latch), 32'd0);

      // Random traffic
      rnd_data = 1;
      repeat (3000) begin
         rand_reqs();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
